c2h_dsc_ring_bypass: RTL and testbench

- Per-channel generator for XDMA C2H descriptor-bypass loads.
- Each channel walks a ring of fixed-size host buffers instead of reloading one constant descriptor.
- Limits descriptors in flight, tracks completions from the C2H AXIS tlast beats, and stalls when the host has not released filled buffers.
- Sits between the PCIe/XDMA bypass ports and the AXIS C2H datapath, in the 250 MHz user clock domain.

---
 rtl/c2h_dsc_ring_bypass_if.sv | 22 ++
 rtl/c2h_dsc_ring_bypass.sv | 118 +++++++++++
 tb/tb_c2h_dsc_ring_bypass.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/c2h_dsc_ring_bypass_if.sv
// XDMA C2H descriptor-bypass bus, one lane per channel packed into flat vectors.
// The generator drives the descriptor (master); the XDMA bypass port returns ready (slave).
interface c2h_dsc_ring_bypass_if #(
  parameter int NR_CHANNELS = 1
);
  logic [NR_CHANNELS-1:0]    dsc_byp_ready;
  logic [NR_CHANNELS-1:0]    dsc_byp_load;
  logic [64*NR_CHANNELS-1:0] dsc_byp_dst_addr;
  logic [64*NR_CHANNELS-1:0] dsc_byp_src_addr;
  logic [28*NR_CHANNELS-1:0] dsc_byp_len;
  logic [16*NR_CHANNELS-1:0] dsc_byp_ctl;

  modport master (
    input  dsc_byp_ready,
    output dsc_byp_load, dsc_byp_dst_addr, dsc_byp_src_addr, dsc_byp_len, dsc_byp_ctl
  );

  modport slave (
    output dsc_byp_ready,
    input  dsc_byp_load, dsc_byp_dst_addr, dsc_byp_src_addr, dsc_byp_len, dsc_byp_ctl
  );
endinterface

// File: rtl/c2h_dsc_ring_bypass.sv
// Per-channel C2H descriptor-bypass generator walking a ring of fixed-size host buffers,
// with in-flight limiting, tlast-based completion tracking and host release accounting.
//
// state | meaning
// IDLE  | no descriptor offered; waits for enable and room in ring / in-flight budget
// OFFER | descriptor presented on the bypass port, held until XDMA accepts it
module c2h_dsc_ring_bypass #(
  parameter int          NR_CHANNELS  = 1,
  parameter int          RING_ENTRIES = 16,
  parameter logic [27:0] BUF_LEN      = 28'h1000,
  parameter logic [63:0] BASE_ADDR    = 64'h1_0000_0000,
  parameter int          MAX_INFLIGHT = 4,
  parameter logic [15:0] CTL_VALUE    = 16'h0,
  parameter int          IW           = $clog2(RING_ENTRIES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_CHANNELS-1:0]        enable,
  c2h_dsc_ring_bypass_if.master         byp,
  input  logic [NR_CHANNELS-1:0]        c2h_tlast_fire,
  input  logic [NR_CHANNELS-1:0]        rel_valid,
  input  logic [(IW+1)*NR_CHANNELS-1:0] rel_cnt,
  output logic [IW*NR_CHANNELS-1:0]     wr_idx,
  output logic [4*NR_CHANNELS-1:0]      inflight,
  output logic [(IW+1)*NR_CHANNELS-1:0] filled,
  output logic [2*NR_CHANNELS-1:0]      err
);

  typedef enum logic {IDLE, OFFER} state_e;

  localparam int SW = IW + 5;

  for (genvar ch = 0; ch < NR_CHANNELS; ch++) begin : g_ch
    localparam logic [63:0] CH_BASE = BASE_ADDR + 64'(ch) * 64'(RING_ENTRIES) * 64'(BUF_LEN);

    state_e        state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [3:0]    inflight_q, inflight_d;
    logic [IW:0]   filled_q, filled_d;
    logic [1:0]    err_q, err_d;
    logic [63:0]   dst_q, dst_d;

    logic          accept;
    logic          comp_ok;
    logic [IW:0]   rel_cnt_ch;
    logic [IW+1:0] filled_inc;
    logic [SW-1:0] occ_q, occ_d;
    logic          elig_q, elig_d;

    assign rel_cnt_ch = rel_cnt[ch*(IW+1) +: IW+1];

    always_comb begin
      accept     = (state_q == OFFER) && byp.dsc_byp_ready[ch];
      comp_ok    = c2h_tlast_fire[ch] && (inflight_q != 4'd0);
      err_d      = err_q;
      if (c2h_tlast_fire[ch] && (inflight_q == 4'd0)) err_d[0] = 1'b1;

      inflight_d = inflight_q + 4'(accept) - 4'(comp_ok);

      // One bit of headroom so a release checked against filled+1 cannot wrap.
      filled_inc = {1'b0, filled_q} + (IW+2)'(comp_ok);
      filled_d   = (IW+1)'(filled_inc);
      if (rel_valid[ch]) begin
        if ((IW+2)'(rel_cnt_ch) > filled_inc) begin
          filled_d = '0;
          err_d[1] = 1'b1;
        end else begin
          filled_d = (IW+1)'(filled_inc - (IW+2)'(rel_cnt_ch));
        end
      end

      wr_idx_d = wr_idx_q + IW'(accept);
      dst_d    = CH_BASE + 64'(wr_idx_d) * 64'(BUF_LEN);

      occ_q  = SW'(inflight_q) + SW'(filled_q);
      occ_d  = SW'(inflight_d) + SW'(filled_d);
      elig_q = enable[ch] && (inflight_q < 4'(MAX_INFLIGHT)) && (occ_q < SW'(RING_ENTRIES));
      elig_d = enable[ch] && (inflight_d < 4'(MAX_INFLIGHT)) && (occ_d < SW'(RING_ENTRIES));

      state_d = state_q;
      case (state_q)
        IDLE:    if (elig_q) state_d = OFFER;
        OFFER:   if (accept) state_d = elig_d ? OFFER : IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= IDLE;
        wr_idx_q   <= '0;
        inflight_q <= '0;
        filled_q   <= '0;
        err_q      <= '0;
        dst_q      <= CH_BASE;
      end else begin
        state_q    <= state_d;
        wr_idx_q   <= wr_idx_d;
        inflight_q <= inflight_d;
        filled_q   <= filled_d;
        err_q      <= err_d;
        dst_q      <= dst_d;
      end
    end

    assign byp.dsc_byp_load[ch]              = (state_q == OFFER);
    assign byp.dsc_byp_dst_addr[ch*64 +: 64] = dst_q;
    assign byp.dsc_byp_src_addr[ch*64 +: 64] = 64'd0;
    assign byp.dsc_byp_len[ch*28 +: 28]      = BUF_LEN;
    assign byp.dsc_byp_ctl[ch*16 +: 16]      = CTL_VALUE;

    assign wr_idx[ch*IW +: IW]         = wr_idx_q;
    assign inflight[ch*4 +: 4]         = inflight_q;
    assign filled[ch*(IW+1) +: IW+1]   = filled_q;
    assign err[ch*2 +: 2]              = err_q;
  end

endmodule

// File: tb/tb_c2h_dsc_ring_bypass.sv
// Bench for c2h_dsc_ring_bypass: a 1-channel/4-entry instance and a 2-channel/16-entry
// instance, each checked every cycle against a counts-level model plus literal checkpoints.
module tb_c2h_dsc_ring_bypass;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // instance A: 1 channel, 4 entries
  logic       rst_a;
  logic [0:0] en_a, tl_a, rv_a;
  logic [2:0] rc_a;
  logic [1:0] wr_a;
  logic [3:0] inf_a;
  logic [2:0] fil_a;
  logic [1:0] err_a;
  c2h_dsc_ring_bypass_if #(.NR_CHANNELS(1)) ifa ();

  // instance B: 2 channels, 16 entries
  logic       rst_b;
  logic [1:0] en_b, tl_b, rv_b;
  logic [9:0] rc_b;
  logic [7:0] wr_b;
  logic [7:0] inf_b;
  logic [9:0] fil_b;
  logic [3:0] err_b;
  c2h_dsc_ring_bypass_if #(.NR_CHANNELS(2)) ifb ();

  c2h_dsc_ring_bypass #(.NR_CHANNELS(1), .RING_ENTRIES(4), .MAX_INFLIGHT(4)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .byp(ifa.master),
    .c2h_tlast_fire(tl_a), .rel_valid(rv_a), .rel_cnt(rc_a),
    .wr_idx(wr_a), .inflight(inf_a), .filled(fil_a), .err(err_a)
  );

  c2h_dsc_ring_bypass #(.NR_CHANNELS(2), .RING_ENTRIES(16), .MAX_INFLIGHT(4)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .byp(ifb.master),
    .c2h_tlast_fire(tl_b), .rel_valid(rv_b), .rel_cnt(rc_b),
    .wr_idx(wr_b), .inflight(inf_b), .filled(fil_b), .err(err_b)
  );

  // Model slots: 0 = A ch0, 1 = B ch0, 2 = B ch1
  int m_load[3] = '{0, 0, 0};
  int m_wr[3]   = '{0, 0, 0};
  int m_inf[3]  = '{0, 0, 0};
  int m_fil[3]  = '{0, 0, 0};
  int m_err[3]  = '{0, 0, 0};
  int acc_cnt[3] = '{0, 0, 0};
  longint unsigned acc_q0[$], acc_q1[$], acc_q2[$];

  function automatic int ring_of(int s);
    return (s == 0) ? 4 : 16;
  endfunction

  function automatic longint unsigned exp_dst(int s);
    int ch = (s == 2) ? 1 : 0;
    return 64'h1_0000_0000 + longint'(ch * ring_of(s) + m_wr[s]) * 64'h1000;
  endfunction

  task automatic step(int s, logic r, logic en, logic rdy, logic tl, logic rv, int rc);
    int acc, cok, inf, fil;
    if (r) begin
      m_load[s] = 0; m_wr[s] = 0; m_inf[s] = 0; m_fil[s] = 0; m_err[s] = 0;
      return;
    end
    acc = (m_load[s] != 0 && rdy) ? 1 : 0;
    cok = (tl && m_inf[s] > 0) ? 1 : 0;
    if (tl && m_inf[s] == 0) m_err[s] = m_err[s] | 1;
    inf = m_inf[s] + acc - cok;
    fil = m_fil[s] + cok;
    if (rv) begin
      if (rc > fil) begin fil = 0; m_err[s] = m_err[s] | 2; end
      else fil = fil - rc;
    end
    if (m_load[s] != 0 && acc == 0) m_load[s] = 1;
    else if (acc == 1) m_load[s] = (en && inf < 4 && inf + fil < ring_of(s)) ? 1 : 0;
    else m_load[s] = (en && m_inf[s] < 4 && m_inf[s] + m_fil[s] < ring_of(s)) ? 1 : 0;
    m_wr[s]  = (m_wr[s] + acc) % ring_of(s);
    m_inf[s] = inf;
    m_fil[s] = fil;
  endtask

  always @(posedge clk) begin
    step(0, rst_a, en_a[0], ifa.dsc_byp_ready[0], tl_a[0], rv_a[0], int'(rc_a));
    step(1, rst_b, en_b[0], ifb.dsc_byp_ready[0], tl_b[0], rv_b[0], int'(rc_b[4:0]));
    step(2, rst_b, en_b[1], ifb.dsc_byp_ready[1], tl_b[1], rv_b[1], int'(rc_b[9:5]));
  end

  task automatic chk(int s, logic ld, logic [63:0] dst, logic [63:0] src, logic [27:0] len,
                     logic [15:0] ctl, int wr, int inf, int fil, int er);
    n_total++;
    if (int'(ld) != m_load[s] || dst != exp_dst(s) || src != 64'd0 || len != 28'h1000 ||
        ctl != 16'h0 || wr != m_wr[s] || inf != m_inf[s] || fil != m_fil[s] || er != m_err[s]) begin
      n_bad++;
      $display("FAIL model_slot%0d t=%0t got load=%0d dst=%h wr=%0d inf=%0d fil=%0d err=%0d src=%h len=%h ctl=%h exp load=%0d dst=%h wr=%0d inf=%0d fil=%0d err=%0d",
               s, $time, ld, dst, wr, inf, fil, er, src, len, ctl,
               m_load[s], exp_dst(s), m_wr[s], m_inf[s], m_fil[s], m_err[s]);
    end
  endtask

  always @(negedge clk) begin
    chk(0, ifa.dsc_byp_load[0], ifa.dsc_byp_dst_addr[63:0], ifa.dsc_byp_src_addr[63:0],
        ifa.dsc_byp_len[27:0], ifa.dsc_byp_ctl[15:0],
        int'(wr_a), int'(inf_a), int'(fil_a), int'(err_a));
    chk(1, ifb.dsc_byp_load[0], ifb.dsc_byp_dst_addr[63:0], ifb.dsc_byp_src_addr[63:0],
        ifb.dsc_byp_len[27:0], ifb.dsc_byp_ctl[15:0],
        int'(wr_b[3:0]), int'(inf_b[3:0]), int'(fil_b[4:0]), int'(err_b[1:0]));
    chk(2, ifb.dsc_byp_load[1], ifb.dsc_byp_dst_addr[127:64], ifb.dsc_byp_src_addr[127:64],
        ifb.dsc_byp_len[55:28], ifb.dsc_byp_ctl[31:16],
        int'(wr_b[7:4]), int'(inf_b[7:4]), int'(fil_b[9:5]), int'(err_b[3:2]));
    if (ifa.dsc_byp_load[0] && ifa.dsc_byp_ready[0]) begin
      acc_cnt[0]++; acc_q0.push_back(ifa.dsc_byp_dst_addr[63:0]);
    end
    if (ifb.dsc_byp_load[0] && ifb.dsc_byp_ready[0]) begin
      acc_cnt[1]++; acc_q1.push_back(ifb.dsc_byp_dst_addr[63:0]);
    end
    if (ifb.dsc_byp_load[1] && ifb.dsc_byp_ready[1]) begin
      acc_cnt[2]++; acc_q2.push_back(ifb.dsc_byp_dst_addr[127:64]);
    end
  end

  task automatic lit(string name, longint unsigned got, longint unsigned exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic longint unsigned qget(int s, int i);
    if (s == 0) return (i < acc_q0.size()) ? acc_q0[i] : 64'd0;
    if (s == 1) return (i < acc_q1.size()) ? acc_q1[i] : 64'd0;
    return (i < acc_q2.size()) ? acc_q2[i] : 64'd0;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] d0;
  bit          stable;

  initial begin
    rst_a = 1'b1; en_a = '0; tl_a = '0; rv_a = '0; rc_a = '0; ifa.dsc_byp_ready = '0;
    rst_b = 1'b1; en_b = '0; tl_b = '0; rv_b = '0; rc_b = '0; ifb.dsc_byp_ready = '0;
    tick(2);
    rst_a = 1'b0; rst_b = 1'b0;

    lit("rst_a_load", ifa.dsc_byp_load, 0);
    lit("rst_a_dst", ifa.dsc_byp_dst_addr, 64'h1_0000_0000);
    lit("rst_a_cnts", {wr_a, inf_a, fil_a, err_a}, 0);
    lit("rst_b_ch1_dst", ifb.dsc_byp_dst_addr[127:64], 64'h1_0001_0000);

    // In-flight limit on B ch0 (16-entry ring, so only the limit applies)
    en_b = 2'b01; ifb.dsc_byp_ready = 2'b11;
    tick(12);
    lit("inflt_acc", acc_cnt[1], 4);
    lit("inflt_inf", inf_b[3:0], 4);
    lit("inflt_load", ifb.dsc_byp_load[0], 0);
    tl_b = 2'b01;
    tick();
    tl_b = 2'b00;
    lit("inflt_tl_load_same", ifb.dsc_byp_load[0], 0);
    tick();
    lit("inflt_tl_load_next", ifb.dsc_byp_load[0], 1);

    // Channel 1 runs with channel 0 disabled
    en_b = 2'b10;
    tick(10);
    lit("two_ch0_acc", acc_cnt[1], 5);
    lit("two_ch1_acc", acc_cnt[2], 4);
    lit("two_ch1_first_dst", qget(2, 0), 64'h1_0001_0000);
    lit("two_ch1_last_dst", qget(2, 3), 64'h1_0001_3000);
    lit("two_ch1_inf", inf_b[7:4], 4);

    // Acceptance and wrap on A
    en_a = 1'b1; ifa.dsc_byp_ready = 1'b1;
    tick(10);
    lit("wrap_acc", acc_cnt[0], 4);
    lit("wrap_dst0", qget(0, 0), 64'h1_0000_0000);
    lit("wrap_dst1", qget(0, 1), 64'h1_0000_1000);
    lit("wrap_dst2", qget(0, 2), 64'h1_0000_2000);
    lit("wrap_dst3", qget(0, 3), 64'h1_0000_3000);
    lit("wrap_wr", wr_a, 0);

    // Ring full: complete all, release none
    tl_a = 1'b1;
    tick(4);
    tl_a = 1'b0;
    tick(3);
    lit("full_fil", fil_a, 4);
    lit("full_inf", inf_a, 0);
    lit("full_load", ifa.dsc_byp_load, 0);
    rv_a = 1'b1; rc_a = 3'd2;
    tick();
    rv_a = 1'b0;
    tick(8);
    lit("rel2_acc", acc_cnt[0], 6);
    lit("rel2_dst4_wrapped", qget(0, 4), 64'h1_0000_0000);
    lit("rel2_dst5", qget(0, 5), 64'h1_0000_1000);

    // Backpressure hold
    ifa.dsc_byp_ready = 1'b0; rv_a = 1'b1; rc_a = 3'd2;
    tick();
    rv_a = 1'b0;
    tick(2);
    lit("bp_load", ifa.dsc_byp_load, 1);
    d0 = ifa.dsc_byp_dst_addr;
    lit("bp_dst", d0, 64'h1_0000_2000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifa.dsc_byp_dst_addr != d0 || inf_a != 4'd2 || !ifa.dsc_byp_load[0]) stable = 1'b0;
    end
    lit("bp_stable", stable, 1);
    ifa.dsc_byp_ready = 1'b1;
    tick();
    ifa.dsc_byp_ready = 1'b0;
    tick(3);
    lit("bp_one_acc", acc_cnt[0], 7);
    lit("bp_inf", inf_a, 3);

    // Enable drop does not retract; then error paths
    en_a = 1'b0; ifa.dsc_byp_ready = 1'b1;
    tick();
    ifa.dsc_byp_ready = 1'b0;
    tl_a = 1'b1;
    tick(4);
    tl_a = 1'b0;
    lit("err_pre_fil", fil_a, 4);
    rv_a = 1'b1; rc_a = 3'd3;
    tick();
    rv_a = 1'b0;
    tl_a = 1'b1;
    tick();
    tl_a = 1'b0;
    lit("err_spurious", err_a, 1);
    lit("err_spurious_fil", fil_a, 1);
    rv_a = 1'b1; rc_a = 3'd3;
    tick();
    rv_a = 1'b0;
    lit("err_over_fil", fil_a, 0);
    lit("err_over", err_a, 3);

    // Reset during OFFER
    en_a = 1'b1; ifa.dsc_byp_ready = 1'b1;
    tick(2);
    ifa.dsc_byp_ready = 1'b0;
    tick(2);
    lit("midrst_pre_load", ifa.dsc_byp_load, 1);
    lit("midrst_pre_wr", wr_a, 1);
    rst_a = 1'b1;
    tick();
    lit("midrst_load", ifa.dsc_byp_load, 0);
    lit("midrst_wr", wr_a, 0);
    lit("midrst_err", err_a, 0);
    lit("midrst_dst", ifa.dsc_byp_dst_addr, 64'h1_0000_0000);
    rst_a = 1'b0; en_a = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
